// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered active-low one-hot select decoder with direct and auto-scan modes
//
// Optional feature macro: SCAN_DECODER_BLANK_EN (adds the all-off GAP between scan slots).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         1 = outputs may assert, 0 = all outputs inactive (IDLE)
//   mode       0 = direct decode of sel_in, 1 = auto-scan
//   sel_in     channel selected in direct mode
//   ch_mask    per-channel enable; a 0 bit keeps that output inactive
//   y_n        active-low one-hot select, all ones = none selected
//   cur_sel    index of the selected / scanned channel
//   frame_tick one-cycle pulse on the scan wrap from OUT_N-1 to 0
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [2**SEL_W-1:0]   ch_mask,
  output logic [2**SEL_W-1:0]   y_n,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  frame_tick
);

  localparam int OUT_N   = 2**SEL_W;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
`ifdef SCAN_DECODER_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
`endif

`ifdef SCAN_DECODER_BLANK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SHOW, ST_GAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SHOW} state_t;
`endif

  state_t             state, n_state;
  logic [SEL_W-1:0]   idx, n_idx;
  logic [CNT_W-1:0]   cnt, n_cnt;
  logic               n_tick;
  logic [OUT_N-1:0]   n_y;
  logic [SEL_W-1:0]   n_cur;

  // Next-state logic. Outputs are registered from the *next* state so that the
  // edge entering a state already drives that state's select pattern.
  always_comb begin
    n_state = ST_IDLE;
    n_idx   = '0;
    n_cnt   = '0;
    n_tick  = 1'b0;
    if (en) begin
      if (!mode) begin
        n_state = ST_DIRECT;
      end else begin
        n_state = ST_SHOW;
        n_idx   = idx;
        n_cnt   = cnt;
        case (state)
          ST_SHOW: begin
            if (cnt == DWELL_LAST) begin
              n_cnt = '0;
`ifdef SCAN_DECODER_BLANK_EN
              n_state = ST_GAP;
`else
              n_idx  = idx + 1'b1;
              n_tick = (idx == '1);
`endif
            end else begin
              n_cnt = cnt + 1'b1;
            end
          end
`ifdef SCAN_DECODER_BLANK_EN
          ST_GAP: begin
            if (cnt == BLANK_LAST) begin
              n_cnt  = '0;
              n_idx  = idx + 1'b1;
              n_tick = (idx == '1);
            end else begin
              n_state = ST_GAP;
              n_cnt   = cnt + 1'b1;
            end
          end
`endif
          default: begin
            // Entering scan from IDLE or DIRECT: restart at channel 0, no tick.
            n_idx = '0;
            n_cnt = '0;
          end
        endcase
      end
    end

    n_y   = '1;
    n_cur = '0;
    case (n_state)
      ST_DIRECT: begin
        n_cur = sel_in;
        if (ch_mask[sel_in]) n_y[sel_in] = 1'b0;
      end
      ST_SHOW: begin
        n_cur = n_idx;
        if (ch_mask[n_idx]) n_y[n_idx] = 1'b0;
      end
      default: begin
        n_cur = n_idx;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      y_n        <= '1;
      cur_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= n_state;
      idx        <= n_idx;
      cnt        <= n_cnt;
      y_n        <= n_y;
      cur_sel    <= n_cur;
      frame_tick <= n_tick;
    end
  end

endmodule
